// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  display_pkg
//  Shared constants and types for the scanline compositor: the transparent
//  index, the horizontal repeat encodings and the sync bundle layout.
//  Revision: 1.0
// ============================================================================
package display_pkg;

   localparam int H_RES_DEFAULT   = 640;
   localparam int TRANSPARENT_IDX = 0;

   typedef logic [1:0] scale_t;

   localparam scale_t SCALE_1X = 2'd0;
   localparam scale_t SCALE_2X = 2'd1;
   localparam scale_t SCALE_4X = 2'd2;

   // Bit positions inside the {de, vsync, hsync} bundle
   localparam int SYNC_HSYNC_BIT = 0;
   localparam int SYNC_VSYNC_BIT = 1;
   localparam int SYNC_DE_BIT    = 2;

   typedef struct packed {
      logic de;
      logic vsync;
      logic hsync;
   } sync_t;

   // Right-shift amount for a repeat setting; the reserved code behaves as 1x
   function automatic logic [1:0] scale_shift(input scale_t s);
      case (s)
         SCALE_2X: return 2'd1;
         SCALE_4X: return 2'd2;
         default:  return 2'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_pp.sv
`default_nettype none
// ============================================================================
//  line_buffer_pp
//  One layer's ping-pong scanline pair. Writes go to the back bank; a swap
//  toggles the front select and clears the bank that becomes the back one.
//  A write issued on the swap cycle targets the new back bank and overrides
//  the clear for its entry. The front bank is read through a register.
//  Revision: 1.0
// ============================================================================
module line_buffer_pp #(
   parameter int H_RES       = 640,
   parameter int COLOR_DEPTH = 8,
   parameter int XW          = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   swap,
   input  logic                   we,
   input  logic [XW-1:0]          wx,
   input  logic [COLOR_DEPTH-1:0] wd,
   input  logic [XW-1:0]          rd_idx,
   input  logic                   rd_ok,
   output logic [COLOR_DEPTH-1:0] rd_data,
   output logic                   wr_oob
);

   localparam int            AW    = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam logic [XW:0]   LIMIT = (XW+1)'(H_RES);

   logic [COLOR_DEPTH-1:0] mem [2][H_RES];
   logic                   front_sel;
   logic                   wr_ok;
   logic                   wr_bank;
   logic [AW-1:0]          waddr;
   logic [AW-1:0]          raddr;

   assign wr_ok   = we && ({1'b0, wx} < LIMIT);
   assign wr_oob  = we && !({1'b0, wx} < LIMIT);
   // On a swap the old front becomes the back bank, so the write follows it
   assign wr_bank = swap ? front_sel : ~front_sel;
   assign waddr   = wx[AW-1:0];
   assign raddr   = rd_idx[AW-1:0];

   // Front/back select toggles once per swap cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         front_sel <= 1'b0;
      end else if (swap) begin
         front_sel <= ~front_sel;
      end
   end

   // Bank storage: clear-on-swap first, then the write so it wins its entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < H_RES; i++) begin
               mem[b][i] <= '0;
            end
         end
      end else begin
         if (swap) begin
            for (int i = 0; i < H_RES; i++) begin
               mem[front_sel][i] <= '0;
            end
         end
         if (wr_ok) begin
            mem[wr_bank][waddr] <= wd;
         end
      end
   end

   // Registered front-bank read; out-of-line indices read as transparent
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_ok ? mem[front_sel][raddr] : '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/line_compositor.sv
`default_nettype none
// ============================================================================
//  line_compositor
//  N_LAYERS ping-pong scanline buffers merged per pixel by priority (higher
//  layer wins, index 0 is transparent, bg_color fills the rest), with integer
//  horizontal repeat. Two-stage readout keeps sync aligned with pal_addr.
//  Revision: 1.0
// ============================================================================
module line_compositor
   import display_pkg::*;
#(
   parameter int H_RES       = H_RES_DEFAULT,
   parameter int COLOR_DEPTH = 8,
   parameter int N_LAYERS    = 2,
   parameter int XW          = 10,
   parameter int PAL_AW      = 9,
   parameter int SYNC_W      = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            line_swap,
   input  logic [N_LAYERS-1:0]             layer_we,
   input  logic [N_LAYERS*XW-1:0]          layer_x,
   input  logic [N_LAYERS*COLOR_DEPTH-1:0] layer_d,
   input  logic [COLOR_DEPTH-1:0]          bg_color,
   input  logic [1:0]                      scale,
   input  logic [XW-1:0]                   rd_x,
   input  logic [SYNC_W-1:0]               sync_in,
   output logic [PAL_AW-1:0]               pal_addr,
   output logic [SYNC_W-1:0]               sync_out,
   output logic                            oob_err,
   output logic [15:0]                     swap_count
);

   localparam logic [XW:0]          LIMIT  = (XW+1)'(H_RES);
   localparam logic [COLOR_DEPTH-1:0] TRANSP = COLOR_DEPTH'(TRANSPARENT_IDX);

   scale_t                   active_scale;
   logic [XW-1:0]            idx;
   logic                     idx_ok;
   logic                     idx_ok_s1;
   logic [SYNC_W-1:0]        sync_s1;
   logic [COLOR_DEPTH-1:0]   layer_q [N_LAYERS];
   logic [N_LAYERS-1:0]      oob_hits;
   logic [COLOR_DEPTH-1:0]   pix;

   assign idx    = rd_x >> scale_shift(active_scale);
   assign idx_ok = ({1'b0, idx} < LIMIT);

   generate
      for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
         line_buffer_pp #(
            .H_RES       (H_RES),
            .COLOR_DEPTH (COLOR_DEPTH),
            .XW          (XW)
         ) u_buf (
            .clk     (clk),
            .rst     (rst),
            .swap    (line_swap),
            .we      (layer_we[l]),
            .wx      (layer_x[l*XW +: XW]),
            .wd      (layer_d[l*COLOR_DEPTH +: COLOR_DEPTH]),
            .rd_idx  (idx),
            .rd_ok   (idx_ok),
            .rd_data (layer_q[l]),
            .wr_oob  (oob_hits[l])
         );
      end
   endgenerate

   // Line-level control: repeat setting latched at swap, swap counter, sticky oob
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_scale <= SCALE_1X;
         swap_count   <= '0;
         oob_err      <= 1'b0;
      end else begin
         if (line_swap) begin
            active_scale <= scale;
            swap_count   <= swap_count + 16'd1;
         end
         if (|oob_hits) begin
            oob_err <= 1'b1;
         end
      end
   end

   // Stage 1: index validity and sync travel alongside the buffer reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_ok_s1 <= 1'b0;
         sync_s1   <= '0;
      end else begin
         idx_ok_s1 <= idx_ok;
         sync_s1   <= sync_in;
      end
   end

   // Priority resolve: later (higher) layers overwrite lower ones when opaque
   always_comb begin
      pix = bg_color;
      for (int l = 0; l < N_LAYERS; l++) begin
         if (idx_ok_s1 && (layer_q[l] != TRANSP)) begin
            pix = layer_q[l];
         end
      end
   end

   // Stage 2: blank outside the active area, delay sync by the second stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pal_addr <= '0;
         sync_out <= '0;
      end else begin
         pal_addr <= sync_s1[SYNC_W-1] ? PAL_AW'(pix) : '0;
         sync_out <= sync_s1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_line_compositor.sv
`default_nettype none
// ============================================================================
//  tb_line_compositor
//  Directed stimulus with a scoreboard: each read pushes its expected
//  pal_addr/sync_out with the cycle it should appear; a monitor pops them.
//  Revision: 1.0
// ============================================================================
module tb_line_compositor;

   localparam int H_RES = 640;
   localparam int CD    = 8;
   localparam int NL    = 2;
   localparam int XW    = 10;
   localparam int PAW   = 9;
   localparam int SW    = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              line_swap;
   logic [NL-1:0]     layer_we;
   logic [NL*XW-1:0]  layer_x;
   logic [NL*CD-1:0]  layer_d;
   logic [CD-1:0]     bg_color;
   logic [1:0]        scale;
   logic [XW-1:0]     rd_x;
   logic [SW-1:0]     sync_in;
   logic [PAW-1:0]    pal_addr;
   logic [SW-1:0]     sync_out;
   logic              oob_err;
   logic [15:0]       swap_count;

   int errors = 0;
   int checks = 0;
   int exp_swaps = 0;
   int unsigned cyc = 0;

   typedef struct {
      int unsigned cyc;
      int          pal;
      int          sync;
   } exp_t;

   exp_t q[$];

   line_compositor #(
      .H_RES(H_RES), .COLOR_DEPTH(CD), .N_LAYERS(NL),
      .XW(XW), .PAL_AW(PAW), .SYNC_W(SW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .line_swap  (line_swap),
      .layer_we   (layer_we),
      .layer_x    (layer_x),
      .layer_d    (layer_d),
      .bg_color   (bg_color),
      .scale      (scale),
      .rd_x       (rd_x),
      .sync_in    (sync_in),
      .pal_addr   (pal_addr),
      .sync_out   (sync_out),
      .oob_err    (oob_err),
      .swap_count (swap_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr1(input int l, input int x, input int d);
      layer_we = '0;
      layer_we[l] = 1'b1;
      layer_x[l*XW +: XW] = XW'(x);
      layer_d[l*CD +: CD] = CD'(d);
      step();
      layer_we = '0;
   endtask

   task automatic wr2(input int x0, input int d0, input int x1, input int d1);
      layer_we = 2'b11;
      layer_x  = {XW'(x1), XW'(x0)};
      layer_d  = {CD'(d1), CD'(d0)};
      step();
      layer_we = '0;
   endtask

   task automatic do_swap(input int sc);
      line_swap = 1'b1;
      scale = 2'(sc);
      step();
      line_swap = 1'b0;
      exp_swaps++;
   endtask

   task automatic swap_wr(input int sc, input int l, input int x, input int d);
      layer_we = '0;
      layer_we[l] = 1'b1;
      layer_x[l*XW +: XW] = XW'(x);
      layer_d[l*CD +: CD] = CD'(d);
      line_swap = 1'b1;
      scale = 2'(sc);
      step();
      line_swap = 1'b0;
      layer_we = '0;
      exp_swaps++;
   endtask

   // Expected address is the resolved pixel when de is high, else 0
   task automatic rd(input int x, input int s, input int pix);
      exp_t e;
      rd_x    = XW'(x);
      sync_in = SW'(s);
      e.cyc   = cyc + 2;
      e.pal   = s[2] ? pix : 0;
      e.sync  = s;
      q.push_back(e);
      step();
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 10) begin
         step();
         n++;
      end
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries still pending, expected 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: compare each expectation on the cycle it is due
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         if (e.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL late_entry: due cycle %0d now %0d", e.cyc, cyc);
         end else begin
            check("pal_addr", int'(pal_addr), e.pal);
            check("sync_out", int'(sync_out), e.sync);
         end
      end
   end

   initial begin
      rst = 1'b1;
      line_swap = 1'b0;
      layer_we = '0;
      layer_x = '0;
      layer_d = '0;
      bg_color = 8'h07;
      scale = 2'd0;
      rd_x = '0;
      sync_in = '0;
      #2;
      check("rst_pal", int'(pal_addr), 0);
      check("rst_sync", int'(sync_out), 0);
      check("rst_swaps", int'(swap_count), 0);
      check("rst_oob", int'(oob_err), 0);
      #10 rst = 1'b0;
      step();

      // Priority and transparency
      wr2(5, 8'h12, 5, 8'h34);
      wr1(0, 6, 8'h12);
      wr1(1, 6, 8'h00);
      do_swap(0);
      rd(5, 3'b100, 'h34);
      rd(6, 3'b101, 'h12);
      rd(7, 3'b110, 'h07);
      drain();
      check("swap_count_1", int'(swap_count), exp_swaps);

      // Clear on swap
      wr1(0, 10, 8'hAA);
      do_swap(0);
      rd(10, 3'b100, 'hAA);
      do_swap(0);
      rd(10, 3'b100, 'h07);
      do_swap(0);
      rd(10, 3'b100, 'h07);
      drain();
      check("swap_count_4", int'(swap_count), exp_swaps);

      // Write landing on the swap cycle
      swap_wr(0, 0, 3, 8'h55);
      do_swap(0);
      rd(3, 3'b100, 'h55);
      rd(4, 3'b100, 'h07);
      drain();

      // Horizontal repeat
      for (int i = 0; i < 4; i++) wr1(0, i, i + 1);
      do_swap(1);
      for (int i = 0; i < 8; i++) rd(i, 3'b100, i / 2 + 1);
      for (int i = 0; i < 4; i++) wr1(0, i, i + 1);
      do_swap(2);
      for (int i = 4; i < 8; i++) rd(i, 3'b100, 2);
      rd(3, 3'b100, 1);
      for (int i = 0; i < 4; i++) wr1(0, i, i + 1);
      do_swap(3);
      rd(1, 3'b100, 2);
      rd(3, 3'b100, 4);
      drain();

      // Boundaries: last pixel, dropped write, out-of-line read, blanking
      check("oob_before", int'(oob_err), 0);
      wr2(639, 8'h66, 640, 8'h99);
      check("oob_set", int'(oob_err), 1);
      do_swap(0);
      rd(639, 3'b100, 'h66);
      rd(640, 3'b100, 'h07);
      rd(645, 3'b111, 'h07);
      rd(639, 3'b011, 'h66);
      rd(639, 3'b001, 'h66);
      drain();
      check("oob_sticky", int'(oob_err), 1);

      // Asynchronous reset in the middle of a line
      wr1(1, 20, 8'h44);
      do_swap(0);
      rd_x = XW'(20);
      sync_in = 3'b100;
      step();
      step();
      step();
      check("pre_rst_pal", int'(pal_addr), 'h44);
      #3 rst = 1'b1;
      #1;
      check("async_pal", int'(pal_addr), 0);
      check("async_sync", int'(sync_out), 0);
      check("async_swaps", int'(swap_count), 0);
      check("async_oob", int'(oob_err), 0);
      exp_swaps = 0;
      #2 rst = 1'b0;
      step();
      rd(20, 3'b100, 'h07);
      rd(5, 3'b100, 'h07);
      do_swap(0);
      rd(20, 3'b100, 'h07);
      rd(639, 3'b100, 'h07);
      drain();
      check("swaps_after_rst", int'(swap_count), exp_swaps);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
